// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory: queues word
// stores, drains one per cycle, and arbitrates the port against loads.
// Build option: define STBUF_FWD_EN to forward buffered data to loads; otherwise
// a load that hits the buffer stalls until the matching stores have drained.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Run,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall,
  input  logic [DW-1:0] mem_rdata,
  output logic          MemWr,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] mem_wdata,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Store handshake: a store transfers on a posedge where st_valid && st_ready.
  // st_ready depends only on Run and fullness, never on st_valid.

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  logic full;
  logic ld_hit;
  logic ld_block;
  logic do_enq;
  logic do_drain;
`ifdef STBUF_FWD_EN
  logic [DW-1:0] fwd_data;
`endif

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = Run & ~full;
  assign do_enq   = st_valid & st_ready;

  // Valid entries are contiguous from head, so scanning head..head+DEPTH-1 and
  // keeping the last hit yields the youngest matching store.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    ld_hit = 1'b0;
`ifdef STBUF_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && (ent_addr[idx] == ld_addr)) begin
        ld_hit = 1'b1;
`ifdef STBUF_FWD_EN
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

`ifdef STBUF_FWD_EN
  assign ld_block = 1'b0;
  assign ld_data  = (Run && ld_valid && ld_hit) ? fwd_data : mem_rdata;
`else
  // Without forwarding, a hit keeps draining until the address leaves the buffer.
  assign ld_block = ld_hit;
  assign ld_data  = mem_rdata;
`endif

  assign do_drain  = Run & (full | (ld_valid ? ld_block : ~empty));
  assign ld_stall  = Run & ld_valid & (full | ld_block);
  assign MemWr     = do_drain;
  assign Addr      = do_drain ? ent_addr[head] : ld_addr;
  assign mem_wdata = do_drain ? ent_data[head] : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (do_drain) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (do_enq) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      case ({do_enq, do_drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: vld gates every use of it.
  always_ff @(posedge Clk) begin
    if (do_enq) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based model of buffered stores plus a model
// memory predicts every port each cycle under directed and random traffic.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic Clk, Rst_n, Run, st_valid, st_ready, ld_valid, ld_stall, MemWr, empty;
  logic [AW-1:0] st_addr, ld_addr, Addr;
  logic [DW-1:0] st_data, ld_data, mem_rdata, mem_wdata;

  logic [DW-1:0] env_mem [16] = '{default: '0};
  logic [DW-1:0] ref_mem [16] = '{default: '0};

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t exp_q[$];

  int total = 0;
  int bad   = 0;
  logic exp_stall;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_rdata(mem_rdata), .MemWr(MemWr), .Addr(Addr), .mem_wdata(mem_wdata),
    .empty(empty)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // data memory: combinational read, write on negedge
  assign mem_rdata = env_mem[Addr[3:0]];
  always @(negedge Clk) if (MemWr) env_mem[Addr[3:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check at posedge+4, update model at posedge.
  task automatic step(input logic run, input logic sv, input logic [AW-1:0] sa,
                      input logic [DW-1:0] sd, input logic lv, input logic [AW-1:0] la);
    logic full, emp, hit, drain, stall, rdy;
    logic [DW-1:0] fwd, exp_ld, exp_wd;
    logic [AW-1:0] exp_a;
    Run = run; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    #3;
    full = (exp_q.size() == DEPTH);
    emp  = (exp_q.size() == 0);
    hit  = 1'b0;
    fwd  = '0;
    foreach (exp_q[i]) if (exp_q[i].a == la) begin hit = 1'b1; fwd = exp_q[i].d; end
    if (!run) begin
      rdy = 1'b0; drain = 1'b0; stall = 1'b0;
    end else begin
      rdy = !full;
      if (full) begin
        drain = 1'b1; stall = lv;
      end else if (lv) begin
        drain = !FWD && hit; stall = !FWD && hit;
      end else begin
        drain = !emp; stall = 1'b0;
      end
    end
    exp_ld = (FWD && hit && lv && run) ? fwd : ref_mem[la[3:0]];
    exp_a  = drain ? exp_q[0].a : la;
    exp_wd = drain ? exp_q[0].d : '0;
    chk("st_ready", 32'(st_ready), 32'(rdy));
    chk("ld_stall", 32'(ld_stall), 32'(stall));
    chk("MemWr", 32'(MemWr), 32'(drain));
    chk("Addr", Addr, exp_a);
    chk("mem_wdata", mem_wdata, exp_wd);
    chk("empty", 32'(empty), 32'(emp));
    if (lv && !stall) chk("ld_data", ld_data, exp_ld);
    exp_stall = stall;
    @(posedge Clk);
    if (drain) begin
      ref_mem[exp_q[0].a[3:0]] = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    if (sv && rdy) exp_q.push_back('{a: sa, d: sd});
    #1;
  endtask

  task automatic idle_until_empty();
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) step(1, 0, '0, '0, 0, '0);
    chk("drained", 32'(empty), 32'(1));
  endtask

  initial begin
    int n;
    Rst_n = 1'b0; Run = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = 32'd3;
    #1;
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_MemWr", 32'(MemWr), 32'(0));
    chk("rst_st_ready", 32'(st_ready), 32'(1));
    chk("rst_ld_stall", 32'(ld_stall), 32'(0));
    chk("rst_Addr", Addr, 32'd3);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // single store reaches memory next cycle
    step(1, 1, 32'd5, 32'hAA, 0, '0);
    step(1, 0, '0, '0, 0, '0);
    chk("mem5", env_mem[5], 32'hAA);
    chk("empty_after_store", 32'(empty), 32'(1));

    // fill with loads blocking the port; fifth cycle sees full
    for (int i = 0; i < 5; i++) step(1, 1, 32'(i + 1), $urandom, 1, 32'd9);
    idle_until_empty();

    // youngest match on address 7
    step(1, 1, 32'd7, 32'd1, 1, 32'd12);
    step(1, 1, 32'd7, 32'd2, 1, 32'd12);
    n = 0;
    do begin
      step(1, 0, '0, '0, 1, 32'd7);
      n++;
    end while (exp_stall && n < 10);
    chk("ld7_cycles", 32'(n), FWD ? 32'd1 : 32'd3);
    idle_until_empty();

    // wrap: interleaved stores and drains
    for (int i = 0; i < 10; i++) step(1, (i % 3) != 2, 32'(i), $urandom, 0, '0);
    idle_until_empty();

    // freeze with two entries buffered
    step(1, 1, 32'd13, 32'h1313, 1, 32'd15);
    step(1, 1, 32'd14, 32'h1414, 1, 32'd15);
    for (int i = 0; i < 3; i++) step(0, 1, 32'd6, $urandom, i == 1, 32'd13);
    chk("freeze_count", 32'(exp_q.size()), 32'd2);
    idle_until_empty();

    // asynchronous reset with three stores queued
    for (int i = 0; i < 3; i++) step(1, 1, 32'(10 + i), $urandom, 1, 32'd15);
    Run = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'(1));
    chk("mid_rst_MemWr", 32'(MemWr), 32'(0));
    chk("mid_rst_st_ready", 32'(st_ready), 32'(1));
    exp_q.delete();
    #2;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, '0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 2) == 0, 32'($urandom_range(0, 7)));
    idle_until_empty();

    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), env_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
